// File: rtl/inject_port_arbiter_if.sv
// Bundle between several injectors, the arbiter and one router local input port.
// The injector/router side drives through master; the arbiter attaches as slave.
interface inject_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int PKTW = 56
);
  logic [NREQ-1:0]      req_in;
  logic [NREQ*PKTW-1:0] pkt_in;
  logic [NREQ-1:0]      full_out;
  logic [NREQ-1:0]      gnt_out;
  logic                 dn_req;
  logic                 dn_gnt;
  logic                 dn_full;
  logic [PKTW-1:0]      pkt_out;
  logic [NREQ*16-1:0]   grant_cnt;
  logic [15:0]          drop_cnt;

  modport master (
    output req_in, pkt_in, dn_gnt, dn_full,
    input  full_out, gnt_out, dn_req, pkt_out, grant_cnt, drop_cnt
  );

  modport slave (
    input  req_in, pkt_in, dn_gnt, dn_full,
    output full_out, gnt_out, dn_req, pkt_out, grant_cnt, drop_cnt
  );
endinterface

// File: rtl/inject_port_arbiter.sv
// Round-robin arbiter that shares one router local input port between NREQ injectors,
// with a bounded wait for the downstream grant and per-injector delivery counters.
//
// state   | meaning
// IDLE    | waiting for a request while the router FIFO has room; picks the winner
// FWD_REQ | packet latched, raising dn_req
// WAIT_DN | dn_req held until dn_gnt or the wait counter hits TIMEOUT
// ACK     | one-cycle grant pulse to the winner, lets it drop req_in
module inject_port_arbiter #(
  parameter int          NREQ    = 4,
  parameter int          PKTW    = 56,
  parameter logic [15:0] TIMEOUT = 16'd1023
) (
  input logic               clk,
  input logic               reset,
  inject_port_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FWD_REQ = 2'b01,
    WAIT_DN = 2'b10,
    ACK     = 2'b11
  } state_t;

  state_t             state, stateNext;
  logic [IW-1:0]      ptr, ptrNext;
  logic [IW-1:0]      idx, idxNext;
  logic [PKTW-1:0]    pktOut, pktNext;
  logic               dnReq, dnReqNext;
  logic [NREQ-1:0]    gnt, gntNext;
  logic [15:0]        waitCnt, waitNext;
  logic [NREQ*16-1:0] grantCnt, grantCntNext;
  logic [15:0]        dropCnt, dropNext;

  logic [IW-1:0]      winner;
  logic [IW-1:0]      cand;
  logic               found;

  // Search starts just past the last granted index, so the previous winner goes last.
  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req_in[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    ptrNext      = ptr;
    idxNext      = idx;
    pktNext      = pktOut;
    dnReqNext    = dnReq;
    gntNext      = gnt;
    waitNext     = waitCnt;
    grantCntNext = grantCnt;
    dropNext     = dropCnt;
    case (state)
      IDLE: begin
        if ((bus.req_in != '0) && !bus.dn_full) begin
          idxNext   = winner;
          pktNext   = bus.pkt_in[int'(winner)*PKTW +: PKTW];
          stateNext = FWD_REQ;
        end
      end
      FWD_REQ: begin
        dnReqNext = 1'b1;
        waitNext  = '0;
        stateNext = WAIT_DN;
      end
      WAIT_DN: begin
        if (bus.dn_gnt) begin
          dnReqNext    = 1'b0;
          gntNext      = '0;
          gntNext[idx] = 1'b1;
          ptrNext      = idx;
          if (grantCnt[int'(idx)*16 +: 16] != 16'hFFFF)
            grantCntNext[int'(idx)*16 +: 16] = grantCnt[int'(idx)*16 +: 16] + 16'd1;
          stateNext    = ACK;
        end else if (waitCnt == TIMEOUT) begin
          // Abort without a grant; the injector keeps requesting and is re-arbitrated.
          dnReqNext = 1'b0;
          if (dropCnt != 16'hFFFF)
            dropNext = dropCnt + 16'd1;
          stateNext = IDLE;
        end else begin
          waitNext  = waitCnt + 16'd1;
          dnReqNext = 1'b1;
        end
      end
      ACK: begin
        gntNext   = '0;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= IW'(NREQ - 1);
      idx      <= '0;
      pktOut   <= '0;
      dnReq    <= 1'b0;
      gnt      <= '0;
      waitCnt  <= '0;
      grantCnt <= '0;
      dropCnt  <= '0;
    end else begin
      state    <= stateNext;
      ptr      <= ptrNext;
      idx      <= idxNext;
      pktOut   <= pktNext;
      dnReq    <= dnReqNext;
      gnt      <= gntNext;
      waitCnt  <= waitNext;
      grantCnt <= grantCntNext;
      dropCnt  <= dropNext;
    end
  end

  always_comb begin
    bus.full_out = '0;
    for (int i = 0; i < NREQ; i++)
      bus.full_out[i] = bus.dn_full | ((state != IDLE) && (idx != IW'(i)));
  end

  assign bus.gnt_out   = gnt;
  assign bus.dn_req    = dnReq;
  assign bus.pkt_out   = pktOut;
  assign bus.grant_cnt = grantCnt;
  assign bus.drop_cnt  = dropCnt;
endmodule
